// File: rtl/uart_cmd_sequencer.sv
// Assembles pairs of UART bytes (high byte first) into 16-bit host commands.
// Optional inter-byte timeout enabled by defining UART_CMD_TIMEOUT_EN.
module uart_cmd_sequencer #(
  parameter int TIMEOUT_CYCLES = 52080,
  parameter int CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        overrun,
  input  logic        clr_overrun,
  output logic        timeout
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HIGH = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [7:0]  hi_q, hi_d;
  logic        clr_rx_rdy_q, clr_rx_rdy_d;
  logic [15:0] cmd_q, cmd_d;
  logic        cmd_rdy_q, cmd_rdy_d;
  logic        overrun_q, overrun_d;
  logic        timeout_q, timeout_d;
  logic        accept_s;

`ifdef UART_CMD_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // A byte held during the acknowledge cycle is the receiver's clear lag, not a new byte.
  assign accept_s = rx_rdy & ~clr_rx_rdy_q;

  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    cmd_d        = cmd_q;
    clr_rx_rdy_d = accept_s;
    timeout_d    = 1'b0;
    cmd_rdy_d    = cmd_rdy_q & ~clr_cmd_rdy;
    overrun_d    = overrun_q & ~clr_overrun;
`ifdef UART_CMD_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          hi_d    = rx_data;
          state_d = HIGH;
`ifdef UART_CMD_TIMEOUT_EN
          cnt_d   = {CNT_W{1'b0}};
`endif
        end else begin
          state_d = IDLE;
        end
      end
      HIGH: begin
`ifdef UART_CMD_TIMEOUT_EN
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_d = cnt_q;
        end
`endif
        if (accept_s) begin
          state_d = IDLE;
          // Completion and new set both take priority over the same-cycle clears.
          if (!cmd_rdy_q || clr_cmd_rdy) begin
            cmd_d     = {hi_q, rx_data};
            cmd_rdy_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
`ifdef UART_CMD_TIMEOUT_EN
        end else if (cnt_q == TO_LAST) begin
          state_d   = IDLE;
          hi_d      = 8'h00;
          timeout_d = 1'b1;
`endif
        end else begin
          state_d = HIGH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hi_q         <= 8'h00;
      clr_rx_rdy_q <= 1'b0;
      cmd_q        <= 16'h0000;
      cmd_rdy_q    <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
      cnt_q        <= {CNT_W{1'b0}};
`endif
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      clr_rx_rdy_q <= clr_rx_rdy_d;
      cmd_q        <= cmd_d;
      cmd_rdy_q    <= cmd_rdy_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
`ifdef UART_CMD_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign clr_rx_rdy = clr_rx_rdy_q;
  assign cmd        = cmd_q;
  assign cmd_rdy    = cmd_rdy_q;
  assign overrun    = overrun_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Self-checking bench for uart_cmd_sequencer: directed scenarios plus random traffic
// against a transaction-level model (pending high byte kept in a queue).
module tb_uart_cmd_sequencer;

  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic        overrun;
  logic        clr_overrun = 1'b0;
  logic        timeout;

  uart_cmd_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .clr_rx_rdy(clr_rx_rdy), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .overrun(overrun), .clr_overrun(clr_overrun),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_ack = 0;

  // Reference model state
  logic [7:0]  pend[$];
  int          age;
  logic        m_ack;
  logic [15:0] m_cmd;
  logic        m_rdy, m_ovr, m_to;

  task automatic chk1(input string tag, input logic got, input logic exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk1 ("clr_rx_rdy", clr_rx_rdy, m_ack);
    chk16("cmd",        cmd,        m_cmd);
    chk1 ("cmd_rdy",    cmd_rdy,    m_rdy);
    chk1 ("overrun",    overrun,    m_ovr);
    chk1 ("timeout",    timeout,    m_to);
  endtask

  task automatic model_reset();
    pend.delete();
    age = 0; m_ack = 1'b0; m_cmd = 16'h0000;
    m_rdy = 1'b0; m_ovr = 1'b0; m_to = 1'b0;
  endtask

  // One clock: apply inputs, advance model at the edge, compare at the falling edge.
  task automatic cycle(input logic rx, input logic [7:0] d, input logic ccr, input logic co);
    logic acc, done, drop;
    logic [7:0] hi;
    rx_rdy = rx; rx_data = d; clr_cmd_rdy = ccr; clr_overrun = co;
    @(posedge clk);
    acc = rx && !m_ack;
    done = 1'b0; drop = 1'b0; m_to = 1'b0;
    if (acc) begin
      if (pend.size() == 0) begin
        pend.push_back(d);
        age = 0;
      end else begin
        hi = pend.pop_front();
        if (!m_rdy || ccr) begin
          m_cmd = {hi, d};
          done = 1'b1;
        end else begin
          drop = 1'b1;
        end
      end
    end else if (pend.size() != 0) begin
      age++;
`ifdef UART_CMD_TIMEOUT_EN
      if (age == TO) begin
        pend.delete();
        m_to = 1'b1;
      end
`endif
    end
    m_ack = acc;
    if (acc) n_ack++;
    m_rdy = done ? 1'b1 : (ccr ? 1'b0 : m_rdy);
    m_ovr = drop ? 1'b1 : (co ? 1'b0 : m_ovr);
    @(negedge clk);
    check_all();
  endtask

  task automatic send(input logic [7:0] b);
    cycle(1'b1, b, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; rx_rdy = 1'b0; clr_cmd_rdy = 1'b0; clr_overrun = 1'b0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
  endtask

  initial begin
    int a0;
    model_reset();
    @(negedge clk);
    do_reset();

    // 1: basic command assembly
    a0 = n_ack;
    send(8'hA5);
    send(8'h3C);
    chk16("t1_cmd", cmd, 16'hA53C);
    chk1 ("t1_rdy", cmd_rdy, 1'b1);
    chk16("t1_acks", 16'(n_ack - a0), 16'd2);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // 2: rx_rdy still high during the clear lag -> one accept
    a0 = n_ack;
    cycle(1'b1, 8'h77, 1'b0, 1'b0);
    cycle(1'b1, 8'h77, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    chk16("t2_acks", 16'(n_ack - a0), 16'd1);
    do_reset();

    // 3: overrun while previous command pending
    send(8'h12); send(8'h34);
    a0 = n_ack;
    send(8'h56); send(8'h78);
    chk16("t3_cmd", cmd, 16'h1234);
    chk1 ("t3_ovr", overrun, 1'b1);
    chk16("t3_acks", 16'(n_ack - a0), 16'd2);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk1 ("t3_ovr_clr", overrun, 1'b0);

    // 4: completion in the same cycle as clr_cmd_rdy
    send(8'hBE);
    cycle(1'b1, 8'hEF, 1'b1, 1'b0);
    chk16("t4_cmd", cmd, 16'hBEEF);
    chk1 ("t4_rdy", cmd_rdy, 1'b1);
    chk1 ("t4_ovr", overrun, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk1 ("t4_rdy_clr", cmd_rdy, 1'b0);

    // 5: inter-byte wait of TO cycles
    send(8'h11);
    for (int i = 0; i < TO; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    send(8'h22); send(8'h33);
`ifdef UART_CMD_TIMEOUT_EN
    chk16("t5_cmd", cmd, 16'h2233);
`else
    chk16("t5_cmd", cmd, 16'h1122);
`endif
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // 6: reset mid-command drops the stored high byte
    do_reset();
    send(8'h99);
    do_reset();
    send(8'h44); send(8'h55);
    chk16("t6_cmd", cmd, 16'h4455);
    chk1 ("t6_rdy", cmd_rdy, 1'b1);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        cycle(1'($urandom_range(0, 2) == 0), 8'($urandom),
              1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0));
      end
    end
    // Long quiet stretch with a half command to exercise the wait path
    send(8'h5A);
    for (int i = 0; i < TO + 5; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    send(8'hC3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
